bech_seq_monitor: RTL

BECH_SEQ_MONITOR -- requirements
Module: bech_seq_monitor

---
 rtl/bech_seq_monitor_pkg.sv | 34 +++
 rtl/sat_counter.sv | 22 ++
 rtl/bech_seq_monitor.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/bech_seq_monitor_pkg.sv
// Shared types and constants for the decoder/follow sequence monitor.
// Vector bit n-1 corresponds to controller output yn.
package bech_seq_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CHK_DEC = 2'd1,
    ST_CHK_FOL = 2'd2
  } trk_state_e;

  typedef enum logic [2:0] {
    F_IDLE   = 3'd0,
    F_Y12    = 3'd1,
    F_Y14    = 3'd2,
    F_Y7     = 3'd3,
    F_Y8Y10  = 3'd4
  } fol_cls_e;

  localparam logic [38:0] ZERO   = 39'h0;
  localparam logic [38:0] Y5     = 39'h10;
  localparam logic [38:0] Y6_Y15 = 39'h4020;
  localparam logic [38:0] Y14    = 39'h2000;
  localparam logic [38:0] Y11    = 39'h400;
  localparam logic [38:0] Y12    = 39'h800;
  localparam logic [38:0] Y7     = 39'h40;
  localparam logic [38:0] Y8_Y9  = 39'h180;
  localparam logic [38:0] Y10    = 39'h200;
  localparam logic [38:0] Y34    = 39'h2_0000_0000;

  localparam logic [1:0] FC_NONE = 2'd0;
  localparam logic [1:0] FC_DEC  = 2'd1;
  localparam logic [1:0] FC_FOL  = 2'd2;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear has priority over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bech_seq_monitor.sv
// Watches the y4 decoder state of a controller: checks the decode output against
// x12/x4/x5 and the following cycle against the latched follow class.
module bech_seq_monitor
  import bech_seq_monitor_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int ALARM_THRESH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [17:0]      x,
  input  logic [38:0]      y,
  output logic             alarm,
  output logic             err_pulse,
  output logic [1:0]       fail_code,
  output logic [CNT_W-1:0] visit_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(ALARM_THRESH);

  trk_state_e  state;
  fol_cls_e    cls;
  logic [38:0] dec_exp;
  fol_cls_e    dec_cls;
  logic        fol_ok;
  logic        viol;
  logic [1:0]  viol_code;
  logic        visit_inc;
  logic        x4, x5, x12;
  logic        unused_x;

  assign x4  = x[3];
  assign x5  = x[4];
  assign x12 = x[11];
  assign unused_x = ^{x[17:12], x[10:5], x[2:0]};

  always_comb begin
    dec_exp = Y5;
    dec_cls = F_Y8Y10;
    if (x12 && x4) begin
      dec_exp = Y5;
      dec_cls = F_Y12;
    end else if (x12 && x5) begin
      dec_exp = Y6_Y15;
      dec_cls = F_Y14;
    end else if (x12) begin
      dec_exp = Y14;
      dec_cls = F_IDLE;
    end else if (x4 && x5) begin
      dec_exp = Y11;
      dec_cls = F_IDLE;
    end else if (x4) begin
      dec_exp = Y5;
      dec_cls = F_Y7;
    end
  end

  // No legal follow vector contains y4, so a re-entry from CHK_FOL is always a violation.
  always_comb begin
    fol_ok = 1'b0;
    case (cls)
      F_Y12:   fol_ok = (y == Y12);
      F_Y14:   fol_ok = (y == Y14);
      F_Y7:    fol_ok = (y == Y7);
      F_Y8Y10: fol_ok = x5 ? (y == Y8_Y9) : (y == Y10);
      default: fol_ok = (y == ZERO) || (y == Y34);
    endcase
  end

  always_comb begin
    viol      = 1'b0;
    viol_code = FC_NONE;
    visit_inc = 1'b0;
    if (en) begin
      case (state)
        ST_IDLE: visit_inc = y[3];
        ST_CHK_DEC: begin
          if (y != dec_exp) begin
            viol      = 1'b1;
            viol_code = FC_DEC;
          end
        end
        ST_CHK_FOL: begin
          visit_inc = y[3];
          if (!fol_ok) begin
            viol      = 1'b1;
            viol_code = FC_FOL;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cls       <= F_IDLE;
      err_pulse <= 1'b0;
      fail_code <= FC_NONE;
      alarm     <= 1'b0;
    end else begin
      err_pulse <= viol;
      if (en) begin
        case (state)
          ST_IDLE: if (y[3]) state <= ST_CHK_DEC;
          ST_CHK_DEC: begin
            cls   <= dec_cls;
            state <= ST_CHK_FOL;
          end
          ST_CHK_FOL: state <= y[3] ? ST_CHK_DEC : ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
      // Clear beats a same-cycle violation; the tracker above still advances.
      if (clr) begin
        fail_code <= FC_NONE;
        alarm     <= 1'b0;
      end else begin
        if (viol && (fail_code == FC_NONE)) fail_code <= viol_code;
        if (err_cnt >= THRESH_C) alarm <= 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_visit_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (visit_inc),
    .cnt (visit_cnt)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (viol),
    .cnt (err_cnt)
  );

endmodule
